// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two cache-controller request/response channels and the
// shared D-memory port, seen from the arbiter (slave) or from the
// controllers/memory side (master).
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              M0_REQ;
  logic              M0_WEN;
  logic              M0_BURST;
  logic [ADDR_W-1:0] M0_ADDR;
  logic [3:0]        M0_BE;
  logic [DATA_W-1:0] M0_WDATA;
  logic              M0_GNT;
  logic              M0_RVALID;
  logic [1:0]        M0_RBEAT;
  logic [DATA_W-1:0] M0_RDATA;
  logic              M0_DONE;

  logic              M1_REQ;
  logic              M1_WEN;
  logic              M1_BURST;
  logic [ADDR_W-1:0] M1_ADDR;
  logic [3:0]        M1_BE;
  logic [DATA_W-1:0] M1_WDATA;
  logic              M1_GNT;
  logic              M1_RVALID;
  logic [1:0]        M1_RBEAT;
  logic [DATA_W-1:0] M1_RDATA;
  logic              M1_DONE;

  logic              D_MEM_CSN;
  logic              D_MEM_WEN;
  logic [ADDR_W-1:0] D_MEM_ADDR;
  logic [3:0]        D_MEM_BE;
  logic [DATA_W-1:0] D_MEM_DOUT;
  logic [DATA_W-1:0] D_MEM_DI;

  modport slave (
    input  M0_REQ, M0_WEN, M0_BURST, M0_ADDR, M0_BE, M0_WDATA,
    output M0_GNT, M0_RVALID, M0_RBEAT, M0_RDATA, M0_DONE,
    input  M1_REQ, M1_WEN, M1_BURST, M1_ADDR, M1_BE, M1_WDATA,
    output M1_GNT, M1_RVALID, M1_RBEAT, M1_RDATA, M1_DONE,
    output D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_BE, D_MEM_DOUT,
    input  D_MEM_DI
  );

  modport master (
    output M0_REQ, M0_WEN, M0_BURST, M0_ADDR, M0_BE, M0_WDATA,
    input  M0_GNT, M0_RVALID, M0_RBEAT, M0_RDATA, M0_DONE,
    output M1_REQ, M1_WEN, M1_BURST, M1_ADDR, M1_BE, M1_WDATA,
    input  M1_GNT, M1_RVALID, M1_RBEAT, M1_RDATA, M1_DONE,
    input  D_MEM_CSN, D_MEM_WEN, D_MEM_ADDR, D_MEM_BE, D_MEM_DOUT,
    output D_MEM_DI
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one D-memory port between the D-cache (M0)
// and I-cache (M1) controllers. Single reads/writes or aligned read bursts;
// the owner keeps the port until its DONE. All outputs are registered.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input logic             CLK,
  input logic             RST,
  dmem_port_arbiter_if.slave bus
);

  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               st_q, st_d;
  logic                 own_q, own_d;
  logic                 pri_q, pri_d;
  logic                 rd_q, rd_d;
  logic                 burst_q, burst_d;
  logic [ADDR_W-BW-1:0] ahi_q, ahi_d;
  logic [BW-1:0]        iss_q, iss_d;
  logic                 cap_q, cap_d;
  logic                 cap_last_q, cap_last_d;
  logic [BW-1:0]        cap_beat_q, cap_beat_d;
  logic                 csn_q, csn_d;
  logic                 mwen_q, mwen_d;
  logic [ADDR_W-1:0]    maddr_q, maddr_d;
  logic [3:0]           mbe_q, mbe_d;
  logic [DATA_W-1:0]    mdout_q, mdout_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           rbeat_q [2];
  logic [1:0]           rbeat_d [2];
  logic [DATA_W-1:0]    rdata_q [2];
  logic [DATA_W-1:0]    rdata_d [2];

  logic                 el0, el1, pick;
  logic                 sel_wen, sel_burst;
  logic [ADDR_W-1:0]    sel_addr;
  logic [3:0]           sel_be;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 is_last;
  logic [BW-1:0]        iss_nx;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-BW-1:0] hi,
                                                  input logic [BW-1:0] k);
    return {hi, k};
  endfunction

  // Request selection: a master whose DONE is on the bus this cycle is still
  // holding its finished request, so it is excluded from this decision.
  always_comb begin
    el0       = bus.M0_REQ & ~done_q[0];
    el1       = bus.M1_REQ & ~done_q[1];
    pick      = (el0 & el1) ? pri_q : el1;
    sel_wen   = pick ? bus.M1_WEN   : bus.M0_WEN;
    sel_burst = pick ? bus.M1_BURST : bus.M0_BURST;
    sel_addr  = pick ? bus.M1_ADDR  : bus.M0_ADDR;
    sel_be    = pick ? bus.M1_BE    : bus.M0_BE;
    sel_wdata = pick ? bus.M1_WDATA : bus.M0_WDATA;
    is_last   = ~burst_q | (iss_q == BW'(BURST_LEN - 1));
    iss_nx    = iss_q + BW'(1);
  end

  // Next-state, command issue and read-beat return.
  always_comb begin
    st_d       = st_q;
    own_d      = own_q;
    pri_d      = pri_q;
    rd_d       = rd_q;
    burst_d    = burst_q;
    ahi_d      = ahi_q;
    iss_d      = iss_q;
    csn_d      = csn_q;
    mwen_d     = mwen_q;
    maddr_d    = maddr_q;
    mbe_d      = mbe_q;
    mdout_d    = mdout_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    done_d     = '0;
    rbeat_d[0] = '0;
    rbeat_d[1] = '0;
    rdata_d[0] = '0;
    rdata_d[1] = '0;
    // A read beat visible on the port this cycle returns data next cycle.
    cap_d      = (st_q == ISSUE) & rd_q;
    cap_beat_d = iss_q;
    cap_last_d = is_last;

    case (st_q)
      IDLE: begin
        if (el0 | el1) begin
          own_d       = pick;
          pri_d       = ~pick;
          rd_d        = sel_wen;
          burst_d     = sel_burst & sel_wen;
          ahi_d       = sel_addr[ADDR_W-1:BW];
          iss_d       = '0;
          gnt_d[pick] = 1'b1;
          csn_d       = 1'b0;
          mwen_d      = sel_wen;
          maddr_d     = (sel_burst & sel_wen) ? beat_addr(sel_addr[ADDR_W-1:BW], '0) : sel_addr;
          mbe_d       = sel_be;
          mdout_d     = sel_wdata;
          st_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (is_last) begin
          csn_d  = 1'b1;
          mwen_d = 1'b1;
          if (rd_q) begin
            st_d = WAIT;
          end else begin
            st_d          = IDLE;
            done_d[own_q] = 1'b1;
          end
        end else begin
          iss_d   = iss_nx;
          maddr_d = beat_addr(ahi_q, iss_nx);
        end
      end
      WAIT: begin
      end
      default: st_d = IDLE;
    endcase

    if (cap_q) begin
      rvalid_d[own_q] = 1'b1;
      rbeat_d[own_q]  = 2'(cap_beat_q);
      rdata_d[own_q]  = bus.D_MEM_DI;
      if (cap_last_q) begin
        done_d[own_q] = 1'b1;
        st_d          = IDLE;
      end
    end
  end

  // State and output registers; reset clears everything, dropping in-flight beats.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q       <= IDLE;
      own_q      <= 1'b0;
      pri_q      <= 1'b0;
      rd_q       <= 1'b0;
      burst_q    <= 1'b0;
      ahi_q      <= '0;
      iss_q      <= '0;
      cap_q      <= 1'b0;
      cap_last_q <= 1'b0;
      cap_beat_q <= '0;
      csn_q      <= 1'b1;
      mwen_q     <= 1'b1;
      maddr_q    <= '0;
      mbe_q      <= '0;
      mdout_q    <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      done_q     <= '0;
      rbeat_q[0] <= '0;
      rbeat_q[1] <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      st_q       <= st_d;
      own_q      <= own_d;
      pri_q      <= pri_d;
      rd_q       <= rd_d;
      burst_q    <= burst_d;
      ahi_q      <= ahi_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      cap_last_q <= cap_last_d;
      cap_beat_q <= cap_beat_d;
      csn_q      <= csn_d;
      mwen_q     <= mwen_d;
      maddr_q    <= maddr_d;
      mbe_q      <= mbe_d;
      mdout_q    <= mdout_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      rbeat_q[0] <= rbeat_d[0];
      rbeat_q[1] <= rbeat_d[1];
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign bus.M0_GNT     = gnt_q[0];
  assign bus.M0_RVALID  = rvalid_q[0];
  assign bus.M0_RBEAT   = rbeat_q[0];
  assign bus.M0_RDATA   = rdata_q[0];
  assign bus.M0_DONE    = done_q[0];
  assign bus.M1_GNT     = gnt_q[1];
  assign bus.M1_RVALID  = rvalid_q[1];
  assign bus.M1_RBEAT   = rbeat_q[1];
  assign bus.M1_RDATA   = rdata_q[1];
  assign bus.M1_DONE    = done_q[1];
  assign bus.D_MEM_CSN  = csn_q;
  assign bus.D_MEM_WEN  = mwen_q;
  assign bus.D_MEM_ADDR = maddr_q;
  assign bus.D_MEM_BE   = mbe_q;
  assign bus.D_MEM_DOUT = mdout_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a synchronous one-cycle-latency
// memory model. Expected values are hand-derived from the memory pattern
// mem[a] = 0xC0DE0000 | a (mem[0x010] = 0xDEADBEEF).
module tb_dmem_port_arbiter;

  localparam logic [31:0] PAT = 32'hC0DE0000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dmem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .BURST_LEN(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: command sampled at the edge, read data valid next cycle.
  logic [31:0] mem [4096];
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= (i == 16) ? 32'hDEADBEEF : (PAT | 32'(i));
      mem_ready <= 1'b1;
    end else if (!bus.D_MEM_CSN) begin
      if (!bus.D_MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (bus.D_MEM_BE[b]) mem[bus.D_MEM_ADDR][8*b +: 8] <= bus.D_MEM_DOUT[8*b +: 8];
      end else begin
        bus.D_MEM_DI <= mem[bus.D_MEM_ADDR];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic wen, input logic burst,
                       input logic [11:0] addr, input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      bus.M0_REQ = req; bus.M0_WEN = wen; bus.M0_BURST = burst;
      bus.M0_ADDR = addr; bus.M0_BE = be; bus.M0_WDATA = wd;
    end else begin
      bus.M1_REQ = req; bus.M1_WEN = wen; bus.M1_BURST = burst;
      bus.M1_ADDR = addr; bus.M1_BE = be; bus.M1_WDATA = wd;
    end
  endtask

  task automatic single_read(input int m, input logic [11:0] a, input logic [31:0] exp,
                             input string tag);
    drive(m, 1'b1, 1'b1, 1'b0, a, 4'hF, 32'h0);
    step();
    chk({tag, "_gnt"}, (m != 0) ? bus.M1_GNT : bus.M0_GNT, 1);
    chk({tag, "_addr"}, bus.D_MEM_ADDR, a);
    step();
    step();
    chk({tag, "_rvalid"}, (m != 0) ? bus.M1_RVALID : bus.M0_RVALID, 1);
    chk({tag, "_rdata"}, (m != 0) ? bus.M1_RDATA : bus.M0_RDATA, exp);
    chk({tag, "_done"}, (m != 0) ? bus.M1_DONE : bus.M0_DONE, 1);
    step();
    drive(m, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g_order[$];
    int   done0_first;
    int   gnt1_first;
    int   ngnt0;
    int   ngnt1;
    bit   pend0;
    bit   pend1;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    step(); step(); step();

    // Reset state
    chk("rst_csn",  bus.D_MEM_CSN, 1);
    chk("rst_wen",  bus.D_MEM_WEN, 1);
    chk("rst_addr", bus.D_MEM_ADDR, 0);
    chk("rst_be",   bus.D_MEM_BE, 0);
    chk("rst_dout", bus.D_MEM_DOUT, 0);
    chk("rst_m_flags", {bus.M0_GNT, bus.M0_RVALID, bus.M0_DONE, bus.M1_GNT, bus.M1_RVALID, bus.M1_DONE}, 0);
    chk("rst_rdata", {bus.M0_RDATA, bus.M1_RDATA}, 0);
    chk("rst_rbeat", {bus.M0_RBEAT, bus.M1_RBEAT}, 0);
    rst = 1'b0;
    step();

    // Test 1: M0 single read of 0x010
    drive(0, 1'b1, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
    step();
    chk("t1_gnt0", bus.M0_GNT, 1);
    chk("t1_gnt1", bus.M1_GNT, 0);
    chk("t1_csn",  bus.D_MEM_CSN, 0);
    chk("t1_addr", bus.D_MEM_ADDR, 12'h010);
    chk("t1_wen",  bus.D_MEM_WEN, 1);
    step();
    chk("t1_gnt0_pulse", bus.M0_GNT, 0);
    chk("t1_csn_off",    bus.D_MEM_CSN, 1);
    chk("t1_rvalid_early", bus.M0_RVALID, 0);
    step();
    chk("t1_rvalid", bus.M0_RVALID, 1);
    chk("t1_rdata",  bus.M0_RDATA, 32'hDEADBEEF);
    chk("t1_rbeat",  bus.M0_RBEAT, 0);
    chk("t1_done",   bus.M0_DONE, 1);
    chk("t1_m1_quiet", {bus.M1_RVALID, bus.M1_DONE, bus.M1_RDATA}, 0);
    step();
    chk("t1_no_regrant", bus.M0_GNT, 0);
    chk("t1_rvalid_off", bus.M0_RVALID, 0);
    drive(0, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    step();

    // Test 2: M1 burst read at 0x02E (aligned to 0x02C)
    drive(1, 1'b1, 1'b1, 1'b1, 12'h02E, 4'hF, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      step();
      chk("t2_csn", bus.D_MEM_CSN, (c <= 4) ? 0 : 1);
      if (c <= 4) chk("t2_addr", bus.D_MEM_ADDR, 12'h02C + c - 1);
      chk("t2_gnt1", bus.M1_GNT, c == 1);
      chk("t2_rvalid1", bus.M1_RVALID, (c >= 3) && (c <= 6));
      if ((c >= 3) && (c <= 6)) begin
        chk("t2_rbeat", bus.M1_RBEAT, c - 3);
        chk("t2_rdata", bus.M1_RDATA, PAT | (32'h02C + 32'(c - 3)));
      end
      chk("t2_done1", bus.M1_DONE, c == 6);
      chk("t2_m0_quiet", {bus.M0_GNT, bus.M0_RVALID, bus.M0_DONE}, 0);
      if (c == 7) drive(1, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    end
    step();

    // Test 3: simultaneous requests from reset, continuous contention
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 12'h100, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 12'h200, 4'hF, 32'h0);
    done0_first = -1;
    gnt1_first  = -1;
    ngnt0 = 0; ngnt1 = 0; pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.M0_GNT) begin g_order.push_back(0); ngnt0++; end
      if (bus.M1_GNT) begin
        g_order.push_back(1); ngnt1++;
        if (gnt1_first < 0) gnt1_first = c;
      end
      if (bus.M0_RVALID) chk("t3_rdata0", bus.M0_RDATA, PAT | 32'h100);
      if (bus.M1_RVALID) chk("t3_rdata1", bus.M1_RDATA, PAT | 32'h200);
      if (pend0) begin
        if (ngnt0 >= 2) drive(0, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
        pend0 = 1'b0;
      end
      if (pend1) begin
        if (ngnt1 >= 2) drive(1, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
        pend1 = 1'b0;
      end
      if (bus.M0_DONE) begin
        pend0 = 1'b1;
        if (done0_first < 0) done0_first = c;
      end
      if (bus.M1_DONE) pend1 = 1'b1;
    end
    drive(0, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    chk("t3_num_grants", g_order.size(), 4);
    for (int i = 0; i < g_order.size() && i < 4; i++) chk("t3_order", g_order[i], i % 2);
    chk("t3_m1_after_m0_done", gnt1_first, done0_first + 1);
    step();

    // Test 4: M0 partial write, then readback; burst flag ignored on a write
    drive(0, 1'b1, 1'b0, 1'b0, 12'h040, 4'b0011, 32'h00001234);
    step();
    chk("t4_gnt0", bus.M0_GNT, 1);
    chk("t4_csn",  bus.D_MEM_CSN, 0);
    chk("t4_wen",  bus.D_MEM_WEN, 0);
    chk("t4_be",   bus.D_MEM_BE, 4'b0011);
    chk("t4_dout", bus.D_MEM_DOUT, 32'h00001234);
    chk("t4_addr", bus.D_MEM_ADDR, 12'h040);
    step();
    chk("t4_done", bus.M0_DONE, 1);
    chk("t4_csn_off", bus.D_MEM_CSN, 1);
    chk("t4_no_rvalid", bus.M0_RVALID, 0);
    step();
    chk("t4_no_rvalid_late", bus.M0_RVALID, 0);
    chk("t4_no_regrant", bus.M0_GNT, 0);
    drive(0, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    step();
    single_read(0, 12'h040, 32'hC0DE1234, "t4_rb");

    drive(1, 1'b1, 1'b0, 1'b1, 12'h043, 4'hF, 32'hA5A5A5A5);
    step();
    chk("t4b_wen",  bus.D_MEM_WEN, 0);
    chk("t4b_addr", bus.D_MEM_ADDR, 12'h043);
    step();
    chk("t4b_done", bus.M1_DONE, 1);
    chk("t4b_csn_off", bus.D_MEM_CSN, 1);
    step();
    drive(1, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    step();
    single_read(1, 12'h043, 32'hA5A5A5A5, "t4b_rb");

    // Test 5: reset during an M1 burst
    drive(1, 1'b1, 1'b1, 1'b1, 12'h080, 4'hF, 32'h0);
    step(); step(); step();
    chk("t5_rvalid_beat0", bus.M1_RVALID, 1);
    chk("t5_rdata_beat0",  bus.M1_RDATA, PAT | 32'h080);
    rst = 1'b1;
    drive(1, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    step();
    rst = 1'b0;
    chk("t5_csn",  bus.D_MEM_CSN, 1);
    chk("t5_addr", bus.D_MEM_ADDR, 0);
    chk("t5_flags", {bus.M1_GNT, bus.M1_RVALID, bus.M1_DONE}, 0);
    for (int c = 5; c <= 8; c++) begin
      step();
      chk("t5_quiet", {bus.D_MEM_CSN, bus.M1_RVALID, bus.M1_DONE}, 3'b100);
    end
    single_read(1, 12'h081, PAT | 32'h081, "t5_new");

    // Test 6: M0 drops REQ mid-burst, M1 requests during the burst
    drive(0, 1'b1, 1'b1, 1'b1, 12'h0C0, 4'hF, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("t6_rvalid0", bus.M0_RVALID, (c >= 3) && (c <= 6));
      if ((c >= 3) && (c <= 6)) chk("t6_rdata0", bus.M0_RDATA, PAT | (32'h0C0 + 32'(c - 3)));
      chk("t6_done0", bus.M0_DONE, c == 6);
      chk("t6_gnt1", bus.M1_GNT, c == 7);
      chk("t6_csn", bus.D_MEM_CSN, ((c >= 1) && (c <= 4)) || (c == 7) ? 0 : 1);
      if (c == 9) begin
        chk("t6_rvalid1", bus.M1_RVALID, 1);
        chk("t6_rdata1",  bus.M1_RDATA, PAT | 32'h0D0);
        chk("t6_done1",   bus.M1_DONE, 1);
      end
      if (c == 2) begin
        drive(0, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b0, 12'h0D0, 4'hF, 32'h0);
      end
      if (c == 10) drive(1, 1'b0, 1'b1, 1'b0, 12'h0, 4'h0, 32'h0);
    end
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
